// File: rtl/fixed_point_pkg.sv
// rtl/fixed_point_pkg.sv - shared FSM encoding and accumulator sizing for the sum-of-squares block
package fixed_point_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Square of a WII-integer-bit sample needs 2*WII-1 integer bits; AW guard bits on top.
  function automatic int calc_wai(input int wii, input int aw);
    return 2 * wii - 1 + aw;
  endfunction

endpackage

// File: rtl/comb_FixedPointZoom.sv
// rtl/comb_FixedPointZoom.sv - combinational signed fixed-point rescale (WII.WIF -> WOI.WOF)
module comb_FixedPointZoom #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter bit ROOF  = 1,
  parameter bit ROUND = 1
) (
  input  logic [WII+WIF-1:0] in_data,
  output logic [WOI+WOF-1:0] out_data,
  output logic               upflow,
  output logic               downflow
);

  localparam int WI = WII + WIF;
  localparam int WO = WOI + WOF;
  localparam int WF = WII + WOF + 1;
  localparam int WC = ((WF > WO) ? WF : WO) + 1;

  // f: input re-expressed with WOF fraction bits plus one headroom bit for the rounding carry
  logic signed [WF-1:0] f;

  generate
    if (WIF >= WOF) begin : g_shr
      localparam int D = WIF - WOF;
      logic signed [WF-1:0] f_t;
      assign f_t = {in_data[WI-1], in_data[WI-1:D]};
      if (ROUND && D > 0) begin : g_rnd
        assign f = f_t + WF'(in_data[D-1]);
      end else begin : g_trn
        assign f = f_t;
      end
    end else begin : g_shl
      localparam int L = WOF - WIF;
      assign f = {in_data[WI-1], in_data, {L{1'b0}}};
    end
  endgenerate

  logic signed [WC-1:0] fe, maxv, minv;
  logic over, under;

  assign fe   = {{(WC-WF){f[WF-1]}}, f};
  assign maxv = {{(WC-WO+1){1'b0}}, {(WO-1){1'b1}}};
  assign minv = {{(WC-WO+1){1'b1}}, {(WO-1){1'b0}}};
  assign over  = fe > maxv;
  assign under = fe < minv;

  always_comb begin
    out_data = fe[WO-1:0];
    if (ROOF && over)  out_data = maxv[WO-1:0];
    if (ROOF && under) out_data = minv[WO-1:0];
  end

  assign upflow   = over | under;
  assign downflow = (in_data != '0) && (f == '0);

endmodule

// File: rtl/seq_fixed_point_sumsq.sv
// rtl/seq_fixed_point_sumsq.sv - packetised sum of squares with saturating accumulator and output rescale
module seq_fixed_point_sumsq
  import fixed_point_pkg::*;
#(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 16,
  parameter int WOF   = 8,
  parameter int AW    = 4,
  parameter bit ROOF  = 1,
  parameter bit ROUND = 1
) (
  input  logic                 rstn,
  input  logic                 clk,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic                 i_last,
  input  logic [WII+WIF-1:0]   i_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [WOI+WOF-1:0]   o_data,
  output logic                 o_upflow,
  output logic                 o_downflow
);

  localparam int WAI = calc_wai(WII, AW);
  localparam int WI  = WII + WIF;
  localparam int WA  = WAI + 2 * WIF;

  state_t        state;
  logic [WA-1:0] acc;
  logic          sat;

  logic signed [2*WI-1:0] prod;
  logic [WA:0]            sum;
  logic                   carry;
  logic [WA-1:0]          acc_nxt;
  logic                   zoom_up;

  // Square is never negative, so the product's sign bit is always 0 and zero-extension is exact.
  assign prod    = $signed(i_data) * $signed(i_data);
  assign sum     = {1'b0, acc} + (WA+1)'($unsigned(prod));
  assign carry   = sum[WA];
  assign acc_nxt = carry ? '1 : sum[WA-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      acc     <= '0;
      sat     <= 1'b0;
      o_valid <= 1'b0;
      i_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_ACC: begin
          if (i_valid) begin
            acc <= acc_nxt;
            sat <= sat | carry;
            if (i_last) begin
              state   <= ST_DONE;
              o_valid <= 1'b1;
              i_ready <= 1'b0;
            end else begin
              state <= ST_ACC;
            end
          end
        end
        ST_DONE: begin
          if (o_ready) begin
            state   <= ST_IDLE;
            acc     <= '0;
            sat     <= 1'b0;
            o_valid <= 1'b0;
            i_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // acc is frozen in DONE, so the rescaled result holds without extra output registers.
  comb_FixedPointZoom #(
    .WII  (WAI + 1),
    .WIF  (2 * WIF),
    .WOI  (WOI),
    .WOF  (WOF),
    .ROOF (ROOF),
    .ROUND(ROUND)
  ) u_zoom (
    .in_data ({1'b0, acc}),
    .out_data(o_data),
    .upflow  (zoom_up),
    .downflow(o_downflow)
  );

  assign o_upflow = zoom_up | sat;

endmodule

// File: tb/tb_seq_fixed_point_sumsq.sv
// tb/tb_seq_fixed_point_sumsq.sv - randomized self-checking bench against an arithmetic sum-of-squares model
module tb_seq_fixed_point_sumsq;

  logic        rstn, clk;
  logic        i_valid, i_ready, i_last;
  logic [15:0] i_data;
  logic        o_valid, o_ready;
  logic [23:0] o_data;
  logic        o_upflow, o_downflow;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] pkt [64];

  seq_fixed_point_sumsq dut (
    .rstn(rstn), .clk(clk),
    .i_valid(i_valid), .i_ready(i_ready), .i_last(i_last), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
    .o_upflow(o_upflow), .o_downflow(o_downflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Exact sum in units of 2^-16, clip at the 35-bit accumulator, round half-up to 2^-8 units.
  task automatic model(input int n, output logic [23:0] d, output logic up, output logic dn);
    longint s, r;
    bit satd;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'($signed(pkt[i])) * longint'($signed(pkt[i]));
    satd = (s > 64'h7_FFFF_FFFF);
    if (satd) s = 64'h7_FFFF_FFFF;
    r  = (s + 128) >>> 8;
    up = satd || (r > 64'h7F_FFFF);
    d  = (r > 64'h7F_FFFF) ? 24'h7F_FFFF : r[23:0];
    dn = (s != 0) && (r == 0);
  endtask

  task automatic run_pkt(input int n, input int hold);
    logic [23:0] ed;
    logic eu, edn;
    model(n, ed, eu, edn);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin
        i_valid = 1'b0; i_data = 16'($urandom); i_last = 1'($urandom); o_ready = 1'($urandom);
        @(negedge clk);
      end
      chk("i_ready_acc", 32'(i_ready), 32'd1);
      i_valid = 1'b1; i_data = pkt[i]; i_last = (i == n - 1); o_ready = 1'b0;
      @(negedge clk);
      if (i < n - 1) chk("early_valid", 32'(o_valid), 32'd0);
    end
    i_valid = 1'b0; i_last = 1'b0;
    chk("o_valid", 32'(o_valid), 32'd1);
    chk("i_ready_done", 32'(i_ready), 32'd0);
    chk("o_data", 32'(o_data), 32'(ed));
    chk("o_upflow", 32'(o_upflow), 32'(eu));
    chk("o_downflow", 32'(o_downflow), 32'(edn));
    repeat (hold) begin
      i_valid = 1'($urandom); i_last = 1'($urandom); i_data = 16'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_data", 32'(o_data), 32'(ed));
      chk("hold_flags", {30'd0, o_upflow, o_downflow}, {30'd0, eu, edn});
      chk("hold_ready", 32'(i_ready), 32'd0);
    end
    i_valid = 1'b0; i_last = 1'b0; o_ready = 1'b1;
    @(negedge clk);
    o_ready = 1'b0;
    chk("release_valid", 32'(o_valid), 32'd0);
    chk("release_ready", 32'(i_ready), 32'd1);
  endtask

  initial begin
    rstn = 1'b0; i_valid = 1'b0; i_last = 1'b0; i_data = '0; o_ready = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(i_ready), 32'd1);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_flags", {30'd0, o_upflow, o_downflow}, 32'd0);

    pkt[0] = 16'h0300; pkt[1] = 16'h0400; run_pkt(2, 0);
    pkt[0] = 16'hFD80; run_pkt(1, 0);
    for (int i = 0; i < 16; i++) pkt[i] = 16'h8000;
    run_pkt(16, 1);
    pkt[0] = 16'h0001; run_pkt(1, 0);
    pkt[0] = 16'h0300; pkt[1] = 16'h0400; run_pkt(2, 5);
    for (int i = 0; i < 40; i++) pkt[i] = 16'h8000;
    run_pkt(40, 2);
    pkt[0] = 16'h0001; run_pkt(1, 0);

    // Partial packet killed by reset must leave no trace.
    for (int i = 0; i < 2; i++) begin
      i_valid = 1'b1; i_data = 16'h7F00; i_last = 1'b0;
      @(negedge clk);
    end
    i_valid = 1'b0; rstn = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(o_valid), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(i_ready), 32'd1);
    chk("midrst_valid2", 32'(o_valid), 32'd0);
    pkt[0] = 16'h0200; run_pkt(1, 0);
    chk("midrst_ref", 32'h400, 32'h400 & 32'hFFFFFF) ;

    for (int k = 0; k < 30; k++) begin
      int n;
      bit full;
      n = $urandom_range(1, 20);
      full = 1'($urandom);
      for (int i = 0; i < n; i++)
        pkt[i] = full ? 16'($urandom) : 16'(int'($urandom_range(0, 1023)) - 512);
      run_pkt(n, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
